// File: rtl/inst_encoder.sv
// rtl/inst_encoder.sv - RV32I instruction encoder writing packed words into IMEM
module inst_encoder #(
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              base_load,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [4:0]        req_op,
    input  logic [4:0]        req_rd,
    input  logic [4:0]        req_rs1,
    input  logic [4:0]        req_rs2,
    input  logic [31:0]       req_imm,
    output logic              imem_wen,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              err_valid,
    output logic [1:0]        err_code,
    output logic [CNT_W-1:0]  wr_count
);

    typedef enum logic [1:0] {S_IDLE, S_ENC, S_WR} state_t;
    typedef enum logic [2:0] {F_R, F_I, F_SH, F_S, F_B, F_J, F_U, F_BAD} fmt_t;

    state_t      state;
    logic [4:0]  op_q, rd_q, rs1_q, rs2_q;
    logic [31:0] imm_q;

    fmt_t        fmt;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [6:0]  opc;
    logic [31:0] enc_word;
    logic [1:0]  enc_err;
    logic        sx11, sx12, sx20;

    // Op id to instruction format, funct3, funct7 and major opcode
    always_comb begin
        fmt = F_BAD;
        f3  = 3'b000;
        f7  = 7'b0000000;
        opc = 7'b0000000;
        case (op_q)
            5'd0:  begin fmt = F_I;  f3 = 3'b010; opc = 7'b0000011; end
            5'd1:  begin fmt = F_S;  f3 = 3'b010; opc = 7'b0100011; end
            5'd2:  begin fmt = F_R;  f3 = 3'b000; end
            5'd3:  begin fmt = F_I;  f3 = 3'b000; opc = 7'b0010011; end
            5'd4:  begin fmt = F_R;  f3 = 3'b000; f7 = 7'b0100000; end
            5'd5:  begin fmt = F_R;  f3 = 3'b111; end
            5'd6:  begin fmt = F_R;  f3 = 3'b110; end
            5'd7:  begin fmt = F_R;  f3 = 3'b100; end
            5'd8:  begin fmt = F_I;  f3 = 3'b111; opc = 7'b0010011; end
            5'd9:  begin fmt = F_I;  f3 = 3'b110; opc = 7'b0010011; end
            5'd10: begin fmt = F_I;  f3 = 3'b100; opc = 7'b0010011; end
            5'd11: begin fmt = F_R;  f3 = 3'b001; end
            5'd12: begin fmt = F_R;  f3 = 3'b101; end
            5'd13: begin fmt = F_R;  f3 = 3'b101; f7 = 7'b0100000; end
            5'd14: begin fmt = F_SH; f3 = 3'b001; end
            5'd15: begin fmt = F_SH; f3 = 3'b101; end
            5'd16: begin fmt = F_SH; f3 = 3'b101; f7 = 7'b0100000; end
            5'd17: begin fmt = F_R;  f3 = 3'b010; end
            5'd18: begin fmt = F_R;  f3 = 3'b011; end
            5'd19: begin fmt = F_I;  f3 = 3'b010; opc = 7'b0010011; end
            5'd20: begin fmt = F_I;  f3 = 3'b011; opc = 7'b0010011; end
            5'd21: begin fmt = F_B;  f3 = 3'b000; end
            5'd22: begin fmt = F_B;  f3 = 3'b001; end
            5'd23: begin fmt = F_B;  f3 = 3'b100; end
            5'd24: begin fmt = F_B;  f3 = 3'b101; end
            5'd25: begin fmt = F_B;  f3 = 3'b110; end
            5'd26: begin fmt = F_B;  f3 = 3'b111; end
            5'd27: begin fmt = F_J;  end
            5'd28: begin fmt = F_I;  f3 = 3'b000; opc = 7'b1100111; end
            5'd29: begin fmt = F_U;  opc = 7'b0110111; end
            5'd30: begin fmt = F_U;  opc = 7'b0010111; end
            default: fmt = F_BAD;
        endcase
    end

    assign sx11 = (&imm_q[31:11]) | ~(|imm_q[31:11]);
    assign sx12 = (&imm_q[31:12]) | ~(|imm_q[31:12]);
    assign sx20 = (&imm_q[31:20]) | ~(|imm_q[31:20]);

    // Illegal op wins over the immediate range check
    always_comb begin
        enc_word = 32'd0;
        enc_err  = 2'b00;
        case (fmt)
            F_R: enc_word = {f7, rs2_q, rs1_q, f3, rd_q, 7'b0110011};
            F_I: begin
                enc_word = {imm_q[11:0], rs1_q, f3, rd_q, opc};
                if (!sx11) enc_err = 2'b10;
            end
            F_SH: begin
                enc_word = {f7, imm_q[4:0], rs1_q, f3, rd_q, 7'b0010011};
                if (|imm_q[31:5]) enc_err = 2'b10;
            end
            F_S: begin
                enc_word = {imm_q[11:5], rs2_q, rs1_q, 3'b010, imm_q[4:0], 7'b0100011};
                if (!sx11) enc_err = 2'b10;
            end
            F_B: begin
                enc_word = {imm_q[12], imm_q[10:5], rs2_q, rs1_q, f3,
                            imm_q[4:1], imm_q[11], 7'b1100011};
                if (!sx12 || imm_q[0]) enc_err = 2'b10;
            end
            F_J: begin
                enc_word = {imm_q[20], imm_q[10:1], imm_q[11], imm_q[19:12], rd_q, 7'b1101111};
                if (!sx20 || imm_q[0]) enc_err = 2'b10;
            end
            F_U: begin
                enc_word = {imm_q[31:12], rd_q, opc};
                if (|imm_q[11:0]) enc_err = 2'b10;
            end
            default: enc_err = 2'b01;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            req_ready  <= 1'b0;
            imem_wen   <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= 32'd0;
            err_valid  <= 1'b0;
            err_code   <= 2'b00;
            wr_count   <= '0;
            op_q       <= 5'd0;
            rd_q       <= 5'd0;
            rs1_q      <= 5'd0;
            rs2_q      <= 5'd0;
            imm_q      <= 32'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    imem_wen  <= 1'b0;
                    err_valid <= 1'b0;
                    if (base_load) begin
                        imem_addr <= base_addr;
                        req_ready <= 1'b1;
                    end else if (req_valid && req_ready) begin
                        op_q      <= req_op;
                        rd_q      <= req_rd;
                        rs1_q     <= req_rs1;
                        rs2_q     <= req_rs2;
                        imm_q     <= req_imm;
                        req_ready <= 1'b0;
                        state     <= S_ENC;
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                S_ENC: begin
                    if (enc_err != 2'b00) begin
                        err_valid <= 1'b1;
                        err_code  <= enc_err;
                    end else begin
                        imem_wen   <= 1'b1;
                        imem_wdata <= enc_word;
                    end
                    state <= S_WR;
                end
                S_WR: begin
                    if (imem_wen) begin
                        imem_addr <= imem_addr + 1'b1;
                        if (wr_count != '1) wr_count <= wr_count + 1'b1;
                    end
                    imem_wen  <= 1'b0;
                    err_valid <= 1'b0;
                    req_ready <= 1'b1;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
